// File: rtl/data_mem_vect.sv
// Vector data memory: DEPTH words of LANES x LANE_W bits, combinational read, synchronous write and clear.
// Optional build macro DMEM_OOR_FLAG_EN adds the out-of-range flag port err.
module data_mem_vect #(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned LANES  = 6,
  parameter int unsigned LANE_W = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         WE,
  input  logic [31:0]                  A,
  input  logic [LANES-1:0][LANE_W-1:0] WD,
`ifdef DMEM_OOR_FLAG_EN
  output logic [LANES-1:0][LANE_W-1:0] RD,
  output logic                         err
`else
  output logic [LANES-1:0][LANE_W-1:0] RD
`endif
);

  localparam int unsigned IDX_W   = 30;
  localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] DEPTH_L = 32'(DEPTH);

  logic [LANES-1:0][LANE_W-1:0] mem [DEPTH];

  logic [IDX_W-1:0] idx;
  logic [AW-1:0]    waddr;
  logic             in_range;
  logic             unused_byte_offset;

  // Word index drops the byte offset; range test done at full width so high bits alias nothing
  assign idx                = A[31:2];
  assign waddr              = idx[AW-1:0];
  assign in_range           = (32'(idx) < DEPTH_L);
  assign unused_byte_offset = ^A[1:0];

  // Clear has priority over write; out-of-range writes are dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (WE && in_range) begin
      mem[waddr] <= WD;
    end
  end

  // Zero-latency read; out-of-range reads return zero
  always_comb begin
    RD = '0;
    if (in_range) begin
      RD = mem[waddr];
    end
  end

`ifdef DMEM_OOR_FLAG_EN
  assign err = ~in_range;
`endif

endmodule

// File: tb/tb_data_mem_vect.sv
// Directed self-checking bench for data_mem_vect at default parameters.
module tb_data_mem_vect;

  localparam int unsigned DEPTH  = 64;
  localparam int unsigned LANES  = 6;
  localparam int unsigned LANE_W = 8;
  localparam int unsigned VW     = LANES * LANE_W;

  logic                         clk = 1'b0;
  logic                         rst;
  logic                         WE;
  logic [31:0]                  A;
  logic [LANES-1:0][LANE_W-1:0] WD;
  logic [LANES-1:0][LANE_W-1:0] RD;
`ifdef DMEM_OOR_FLAG_EN
  logic                         err;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_mem_vect #(.DEPTH(DEPTH), .LANES(LANES), .LANE_W(LANE_W)) dut (
    .clk (clk),
    .rst (rst),
    .WE  (WE),
    .A   (A),
    .WD  (WD),
`ifdef DMEM_OOR_FLAG_EN
    .RD  (RD),
    .err (err)
`else
    .RD  (RD)
`endif
  );

  task automatic do_write(input logic [31:0] addr, input logic [VW-1:0] data);
    @(negedge clk);
    A  = addr;
    WD = data;
    WE = 1'b1;
    @(posedge clk);
    #1;
    WE = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] addrs [5];
    addrs = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
    rst = 1'b1; WE = 1'b0; A = 32'h0; WD = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    foreach (addrs[k]) begin
      A = addrs[k];
      #1;
      checks++;
      if (RD !== '0) begin
        errors++;
        $display("FAIL reset_read A=%h: RD=%h expected 0", A, RD);
      end
    end
    for (int w = 0; w < int'(DEPTH); w++) begin
      A = 32'(w * 4);
      #1;
      checks++;
      if (RD !== '0) begin
        errors++;
        $display("FAIL reset_all_words A=%h: RD=%h expected 0", A, RD);
      end
    end
`ifdef DMEM_OOR_FLAG_EN
    A = 32'h0;
    #1;
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_in_range: err=%b expected 0", err);
    end
`endif
  endtask

  task automatic test_basic_write();
    logic [VW-1:0] v;
    logic [31:0]   nb [4];
    v  = 48'h00_11_22_33_44_55;
    nb = '{32'h4, 32'h8, 32'hC, 32'h10};
    do_write(32'h0, v);
    A = 32'h0;
    #1;
    checks++;
    if (RD !== v) begin
      errors++;
      $display("FAIL basic_write: RD=%h expected %h", RD, v);
    end
    for (int i = 0; i < int'(LANES); i++) begin
      checks++;
      if (RD[i] !== v[i*LANE_W +: LANE_W]) begin
        errors++;
        $display("FAIL lane_order lane %0d: RD=%h expected %h", i, RD[i], v[i*LANE_W +: LANE_W]);
      end
    end
    foreach (nb[k]) begin
      A = nb[k];
      #1;
      checks++;
      if (RD !== '0) begin
        errors++;
        $display("FAIL basic_neighbour A=%h: RD=%h expected 0", A, RD);
      end
    end
    A = 32'h0;
    #1;
    checks++;
    if (RD !== v) begin
      errors++;
      $display("FAIL basic_return: RD=%h expected %h", RD, v);
    end
  endtask

  task automatic test_we_low();
    @(negedge clk);
    A = 32'h0; WD = {LANES{8'hEE}}; WE = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (RD !== 48'h00_11_22_33_44_55) begin
      errors++;
      $display("FAIL we_low_hold: RD=%h expected 001122334455", RD);
    end
  endtask

  task automatic test_byte_offset();
    logic [VW-1:0] v;
    v = 48'hAA_BB_CC_DD_EE_FF;
    do_write(32'h8, v);
    for (int off = 1; off < 4; off++) begin
      A = 32'h8 + 32'(off);
      #1;
      checks++;
      if (RD !== v) begin
        errors++;
        $display("FAIL byte_offset A=%h: RD=%h expected %h", A, RD, v);
      end
    end
    A = 32'h4;
    #1;
    checks++;
    if (RD !== '0) begin
      errors++;
      $display("FAIL offset_neighbour_lo: RD=%h expected 0", RD);
    end
    A = 32'hC;
    #1;
    checks++;
    if (RD !== '0) begin
      errors++;
      $display("FAIL offset_neighbour_hi: RD=%h expected 0", RD);
    end
    A = 32'h3;
    #1;
    checks++;
    if (RD !== 48'h00_11_22_33_44_55) begin
      errors++;
      $display("FAIL offset_word0: RD=%h expected 001122334455", RD);
    end
  endtask

  task automatic test_out_of_range();
    logic [VW-1:0] top;
    top = 48'h12_34_56_78_9A_BC;
    do_write(32'hFC, top);
    A = 32'hFC;
    #1;
    checks++;
    if (RD !== top) begin
      errors++;
      $display("FAIL last_word: RD=%h expected %h", RD, top);
    end
`ifdef DMEM_OOR_FLAG_EN
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_last_word: err=%b expected 0", err);
    end
`endif
    do_write(32'h100, {LANES{8'h5A}});
    A = 32'h100;
    #1;
    checks++;
    if (RD !== '0) begin
      errors++;
      $display("FAIL oor_read: RD=%h expected 0", RD);
    end
`ifdef DMEM_OOR_FLAG_EN
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL err_oor: err=%b expected 1", err);
    end
`endif
    A = 32'hFFFF_FFFC;
    #1;
    checks++;
    if (RD !== '0) begin
      errors++;
      $display("FAIL oor_high_read: RD=%h expected 0", RD);
    end
    A = 32'h0;
    #1;
    checks++;
    if (RD !== 48'h00_11_22_33_44_55) begin
      errors++;
      $display("FAIL oor_no_alias_word0: RD=%h expected 001122334455", RD);
    end
    A = 32'hFC;
    #1;
    checks++;
    if (RD !== top) begin
      errors++;
      $display("FAIL oor_no_alias_top: RD=%h expected %h", RD, top);
    end
  endtask

  task automatic test_read_during_write();
    logic [VW-1:0] old_v;
    logic [VW-1:0] new_v;
    old_v = 48'h01_02_03_04_05_06;
    new_v = 48'h07_08_09_0A_0B_0C;
    do_write(32'h4, old_v);
    @(negedge clk);
    A = 32'h4; WD = new_v; WE = 1'b1;
    #1;
    checks++;
    if (RD !== old_v) begin
      errors++;
      $display("FAIL rdw_before: RD=%h expected %h", RD, old_v);
    end
    @(posedge clk);
    #1;
    WE = 1'b0;
    checks++;
    if (RD !== new_v) begin
      errors++;
      $display("FAIL rdw_after: RD=%h expected %h", RD, new_v);
    end
  endtask

  task automatic test_reset_priority();
    do_write(32'h0, {LANES{8'h11}});
    @(negedge clk);
    A = 32'h0; WD = {LANES{8'h22}}; WE = 1'b1; rst = 1'b1;
    #1;
    checks++;
    if (RD !== {LANES{8'h11}}) begin
      errors++;
      $display("FAIL rst_not_async: RD=%h expected 111111111111", RD);
    end
`ifdef DMEM_OOR_FLAG_EN
    A = 32'h100;
    #1;
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL err_during_rst: err=%b expected 1", err);
    end
    A = 32'h0;
`endif
    @(posedge clk);
    #1;
    rst = 1'b0; WE = 1'b0;
    checks++;
    if (RD !== '0) begin
      errors++;
      $display("FAIL rst_priority: RD=%h expected 0", RD);
    end
    for (int w = 0; w < int'(DEPTH); w++) begin
      A = 32'(w * 4);
      #1;
      checks++;
      if (RD !== '0) begin
        errors++;
        $display("FAIL rst_full_clear A=%h: RD=%h expected 0", A, RD);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_we_low();
    test_byte_offset();
    test_out_of_range();
    test_read_during_write();
    test_reset_priority();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
